tron_pc_unit: RTL and testbench
===============================

# tron_pc_unit

Program-counter and processor-status stage sitting directly downstream of the multicycle controller. Consumes the controller's `pcAdd`/`pcJump`/`pcBranch` strobes, `flagOp`, sign-extended `immediate`, the ALU flag results with `flagWrite`, and register-file port A data. It holds the architectural PC and the five status flags, evaluates branch/jump conditions, and drives the instruction-memory address and the JAL link value.

## Interface
- `WIDTH`, 16, datapath width of `immediate`, `jumpTarget`, `pcLink`
- `ADDRBITS`, 16, PC width; PC arithmetic is modulo 2^ADDRBITS
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `pcAdd`  in  1  advance PC by one
- `pcJump`  in  1  conditional absolute jump to `jumpTarget`
- `pcBranch`  in  1  conditional relative branch by `immediate`
- `flagOp`  in  4  condition code for jump/branch
- `immediate`  in  WIDTH  sign-extended branch displacement
- `jumpTarget`  in  WIDTH  register port A data (jump destination)
- `aluFlags`  in  5  `{N,Z,F,L,C}` from the ALU
- `flagWrite`  in  1  latch `aluFlags` into status register
- `pc`  out  ADDRBITS  current PC / instruction-memory address
- `pcLink`  out  WIDTH  `pc + 1`, zero-extended; written by JAL
- `flags`  out  5  registered `{N,Z,F,L,C}`
- `condTrue`  out  1  `flagOp` evaluated against registered `flags`
- `halted`  out  1  only with `PC_HALT_EN`; else absent

## Operation
- Reset: `pc`=RESET_PC, `flags`=5'b0, `halted`=0; `condTrue` follows from flags (EQ false, UC true).
- Condition codes (on registered flags): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 HI L; 0101 LS !L; 0110 GT N; 0111 LE !N; 1000 FS F; 1001 FC !F; 1010 LO !L&!Z; 1011 HS L|Z; 1100 LT !N&!Z; 1101 GE N|Z; 1110 UC 1; 1111 UC 1 (JAL encoding).
- PC update, priority pcJump > pcBranch > pcAdd:
  - pcJump: condTrue ? `jumpTarget[ADDRBITS-1:0]` : `pc+1`
  - pcBranch: condTrue ? `pc + immediate` : `pc+1`; sum truncated to ADDRBITS, wraps both directions
  - pcAdd: `pc+1`, wraps 2^ADDRBITS-1 -> 0
  - none: hold
- More than one strobe in a cycle is a controller error; priority rule still applies, no other side effect.
- flagWrite: `flags <= aluFlags` at the edge. Same-cycle flagWrite and pcJump/pcBranch: condition uses pre-update flags.
- `pcLink` combinational from current `pc`; the JAL state samples it before its pcAdd edge.

## Timing
- `pc`, `flags`, `halted` registered; visible one cycle after the strobe cycle.
- `condTrue`, `pcLink` combinational, zero latency.
- Reset asserted mid-instruction: state cleared asynchronously; first edge after release acts on strobes of that cycle (controller is in FETCH, so none).
- No handshake; strobes are single-cycle pulses and each is acted on exactly once per asserted edge.

## Configuration
- `TRON_PC_HALT_EN` defined: a taken pcBranch with `immediate`==0 (branch-to-self) sets `halted` at that edge; while `halted`, all PC updates are ignored, `pc` frozen, flagWrite still honoured; cleared only by reset.
- Not defined: no `halted` port; branch-to-self loops normally with `pc` unchanged each branch.

## Structure
- Shared `tron_pkg`: condition-code localparams (EQ..UC), flag bit indices (C=0, L=1, F=2, Z=3, N=4), flag vector width.
- One combinational sub-module `tron_cond_eval` (flagOp, flags -> condTrue); PC/flag registers and next-PC mux in the top.

## Test plan
- Reset release, three pcAdd pulses -> `pc` 0,1,2,3; `pcLink`=4 at end; `flags`=0.
- flagWrite with `aluFlags`=5'b01000 (Z=1), then pcBranch flagOp=0000 immediate=16'hFFFE at pc=5 -> `pc`=3; repeat with flagOp=0001 -> `pc`=6.
- pc=16'hFFFF, pcAdd -> `pc`=0; pc=1, taken branch immediate=-3 -> `pc`=16'hFFFE.
- pcJump flagOp=1111 jumpTarget=16'h0040 with pcAdd also high -> `pc`=16'h0040 (jump wins).
- Same-cycle flagWrite (Z=0) and pcBranch EQ with old Z=1 -> branch taken; following cycle `condTrue` for EQ = 0.
- With `TRON_PC_HALT_EN`: UC branch immediate=0 at pc=9 -> `halted`=1, later pcAdd leaves `pc`=9; async reset mid-cycle -> `pc`=RESET_PC, `halted`=0 immediately.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared TRON definitions: condition codes, status-flag layout and flag vector type.
package tron_pkg;

  localparam int FLAG_W = 5;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  localparam logic [3:0] CC_EQ  = 4'b0000;
  localparam logic [3:0] CC_NE  = 4'b0001;
  localparam logic [3:0] CC_CS  = 4'b0010;
  localparam logic [3:0] CC_CC  = 4'b0011;
  localparam logic [3:0] CC_HI  = 4'b0100;
  localparam logic [3:0] CC_LS  = 4'b0101;
  localparam logic [3:0] CC_GT  = 4'b0110;
  localparam logic [3:0] CC_LE  = 4'b0111;
  localparam logic [3:0] CC_FS  = 4'b1000;
  localparam logic [3:0] CC_FC  = 4'b1001;
  localparam logic [3:0] CC_LO  = 4'b1010;
  localparam logic [3:0] CC_HS  = 4'b1011;
  localparam logic [3:0] CC_LT  = 4'b1100;
  localparam logic [3:0] CC_GE  = 4'b1101;
  localparam logic [3:0] CC_UC  = 4'b1110;
  localparam logic [3:0] CC_JAL = 4'b1111;

  // Field order matches the {N,Z,F,L,C} bit layout of the flag bus.
  typedef struct packed {
    logic n;
    logic z;
    logic f;
    logic l;
    logic c;
  } flags_t;

endpackage

// File: rtl/tron_cond_eval.sv
// Combinational condition-code evaluator: flagOp against the registered status flags.
module tron_cond_eval
  import tron_pkg::*;
(
  input  logic [3:0]        flagOp,
  input  logic [FLAG_W-1:0] flags,
  output logic              condTrue
);

  flags_t f;
  assign f = flags_t'(flags);

  always_comb begin
    condTrue = 1'b0;
    case (flagOp)
      CC_EQ:  condTrue = f.z;
      CC_NE:  condTrue = !f.z;
      CC_CS:  condTrue = f.c;
      CC_CC:  condTrue = !f.c;
      CC_HI:  condTrue = f.l;
      CC_LS:  condTrue = !f.l;
      CC_GT:  condTrue = f.n;
      CC_LE:  condTrue = !f.n;
      CC_FS:  condTrue = f.f;
      CC_FC:  condTrue = !f.f;
      CC_LO:  condTrue = !f.l && !f.z;
      CC_HS:  condTrue = f.l || f.z;
      CC_LT:  condTrue = !f.n && !f.z;
      CC_GE:  condTrue = f.n || f.z;
      default: condTrue = 1'b1;  // UC and the JAL encoding
    endcase
  end

endmodule

// File: rtl/tron_pc_unit.sv
// TRON program counter and status-flag stage: next-PC mux, flag register, JAL link value.
// Optional TRON_PC_HALT_EN: branch-to-self halts the PC until reset.
module tron_pc_unit
  import tron_pkg::*;
#(
  parameter int                  WIDTH    = 16,
  parameter int                  ADDRBITS = 16,
  parameter logic [ADDRBITS-1:0] RESET_PC = '0
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                pcAdd,
  input  logic                pcJump,
  input  logic                pcBranch,
  input  logic [3:0]          flagOp,
  input  logic [WIDTH-1:0]    immediate,
  input  logic [WIDTH-1:0]    jumpTarget,
  input  logic [FLAG_W-1:0]   aluFlags,
  input  logic                flagWrite,
  output logic [ADDRBITS-1:0] pc,
  output logic [WIDTH-1:0]    pcLink,
  output logic [FLAG_W-1:0]   flags,
  output logic                condTrue
`ifdef TRON_PC_HALT_EN
  ,
  output logic                halted
`endif
);

  logic [ADDRBITS-1:0] pc_inc, pc_br, pc_nxt;
  logic                frozen;

  tron_cond_eval u_cond (
    .flagOp   (flagOp),
    .flags    (flags),
    .condTrue (condTrue)
  );

  assign pc_inc = pc + ADDRBITS'(1);
  // Displacement is sign-extended to the PC width so the add wraps both ways.
  assign pc_br  = pc + ADDRBITS'($signed(immediate));
  assign pcLink = WIDTH'(pc_inc);

  always_comb begin
    pc_nxt = pc;
    if (pcJump)        pc_nxt = condTrue ? ADDRBITS'(jumpTarget) : pc_inc;
    else if (pcBranch) pc_nxt = condTrue ? pc_br : pc_inc;
    else if (pcAdd)    pc_nxt = pc_inc;
  end

`ifdef TRON_PC_HALT_EN
  logic halt_set;
  assign halt_set = pcBranch && !pcJump && condTrue && (immediate == '0);
  assign frozen   = halted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         halted <= 1'b0;
    else if (halt_set) halted <= 1'b1;
  end
`else
  assign frozen = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pc <= RESET_PC;
    else if (!frozen) pc <= pc_nxt;
  end

  // Condition is evaluated on the pre-update flags, so a same-edge write never affects it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          flags <= '0;
    else if (flagWrite) flags <= aluFlags;
  end

endmodule

// File: tb/tb_tron_pc_unit.sv
// Directed bench for tron_pc_unit with a behavioural PC/flag model checked every cycle.
module tb_tron_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcAdd = 1'b0, pcJump = 1'b0, pcBranch = 1'b0, flagWrite = 1'b0;
  logic [3:0]  flagOp = 4'd0;
  logic [15:0] immediate = 16'd0, jumpTarget = 16'd0;
  logic [4:0]  aluFlags = 5'd0;
  logic [15:0] pc, pcLink;
  logic [4:0]  flags;
  logic        condTrue;
`ifdef TRON_PC_HALT_EN
  logic        halted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tron_pc_unit #(.WIDTH(16), .ADDRBITS(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcAdd      (pcAdd),
    .pcJump     (pcJump),
    .pcBranch   (pcBranch),
    .flagOp     (flagOp),
    .immediate  (immediate),
    .jumpTarget (jumpTarget),
    .aluFlags   (aluFlags),
    .flagWrite  (flagWrite),
    .pc         (pc),
    .pcLink     (pcLink),
    .flags      (flags),
    .condTrue   (condTrue)
`ifdef TRON_PC_HALT_EN
    ,
    .halted     (halted)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: flags as named booleans, PC as an integer taken modulo 65536.
  int m_pc    = 0;
  int m_flags = 0;
  bit m_halt  = 0;

  function automatic bit cond_of(input int op, input int fl);
    bit n, z, f, l, c;
    n = fl[4]; z = fl[3]; f = fl[2]; l = fl[1]; c = fl[0];
    case (op)
      0: return z;        1: return !z;
      2: return c;        3: return !c;
      4: return l;        5: return !l;
      6: return n;        7: return !n;
      8: return f;        9: return !f;
      10: return !l && !z; 11: return l || z;
      12: return !n && !z; 13: return n || z;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    bit c;
    int imm_s;
    if (reset) begin
      m_pc    <= 0;
      m_flags <= 0;
      m_halt  <= 0;
    end else begin
      c     = cond_of(int'(flagOp), m_flags);
      imm_s = int'($signed(immediate));
      if (!m_halt) begin
        if (pcJump)        m_pc <= c ? int'(jumpTarget) : (m_pc + 1) % 65536;
        else if (pcBranch) m_pc <= c ? (((m_pc + imm_s) % 65536) + 65536) % 65536
                                     : (m_pc + 1) % 65536;
        else if (pcAdd)    m_pc <= (m_pc + 1) % 65536;
      end
`ifdef TRON_PC_HALT_EN
      if (pcBranch && !pcJump && c && imm_s == 0) m_halt <= 1;
`endif
      if (flagWrite) m_flags <= int'(aluFlags);
    end
  end

  always @(negedge clk) begin
    chk("pc_model",     32'(pc),       32'(m_pc));
    chk("flags_model",  32'(flags),    32'(m_flags));
    chk("cond_model",   32'(condTrue), 32'(cond_of(int'(flagOp), m_flags)));
    chk("link_model",   32'(pcLink),   32'((m_pc + 1) % 65536));
`ifdef TRON_PC_HALT_EN
    chk("halt_model",   32'(halted),   32'(m_halt));
`endif
  end

  // Present inputs for one edge, then drop the strobes 1 time unit after it.
  task automatic step(input logic a, input logic j, input logic b, input logic [3:0] op,
                      input logic [15:0] imm, input logic [15:0] jt,
                      input logic [4:0] af, input logic fw);
    pcAdd = a; pcJump = j; pcBranch = b; flagOp = op;
    immediate = imm; jumpTarget = jt; aluFlags = af; flagWrite = fw;
    @(posedge clk); #1;
    pcAdd = 0; pcJump = 0; pcBranch = 0; flagWrite = 0;
  endtask

  task automatic jump_to(input logic [15:0] t);
    step(0, 1, 0, 4'hE, 16'd0, t, 5'd0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    flagOp = 4'h0; #1;
    chk("rst_eq", 32'(condTrue), 32'h0);
    flagOp = 4'hE; #1;
    chk("rst_uc", 32'(condTrue), 32'h1);
`ifdef TRON_PC_HALT_EN
    chk("rst_halt", 32'(halted), 32'h0);
`endif

    step(1, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0); chk("add1", 32'(pc), 32'h1);
    step(1, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0); chk("add2", 32'(pc), 32'h2);
    step(1, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0); chk("add3", 32'(pc), 32'h3);
    chk("link4", 32'(pcLink), 32'h4);
    chk("flags0", 32'(flags), 32'h0);

    step(0, 0, 0, 4'h0, 16'd0, 16'd0, 5'b01000, 1); chk("fw_z", 32'(flags), 32'h08);
    step(0, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0);     chk("nostrobe_hold", 32'(pc), 32'h3);
    jump_to(16'd5);                                   chk("jmp5", 32'(pc), 32'h5);
    step(0, 0, 1, 4'h0, 16'hFFFE, 16'd0, 5'd0, 0);  chk("beq_taken", 32'(pc), 32'h3);
    jump_to(16'd5);
    step(0, 0, 1, 4'h1, 16'hFFFE, 16'd0, 5'd0, 0);  chk("bne_not", 32'(pc), 32'h6);

    jump_to(16'hFFFF);
    step(1, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0);     chk("add_wrap", 32'(pc), 32'h0);
    jump_to(16'd1);
    step(0, 0, 1, 4'hE, 16'hFFFD, 16'd0, 5'd0, 0);  chk("br_wrap", 32'(pc), 32'hFFFE);

    step(1, 1, 0, 4'hF, 16'd0, 16'h0040, 5'd0, 0);  chk("jmp_wins", 32'(pc), 32'h0040);
    chk("link41", 32'(pcLink), 32'h0041);
    step(1, 0, 1, 4'h1, 16'h0010, 16'd0, 5'd0, 0);  chk("br_nt_over_add", 32'(pc), 32'h0041);

    // Flags are still Z=1; clearing them on the same edge must not affect the branch.
    step(0, 0, 1, 4'h0, 16'h0004, 16'd0, 5'd0, 1);  chk("fw_br_old", 32'(pc), 32'h0045);
    flagOp = 4'h0; #1;
    chk("eq_after_fw", 32'(condTrue), 32'h0);
    flagOp = 4'hC; #1;
    chk("lt_clear", 32'(condTrue), 32'h1);
    step(0, 0, 0, 4'h0, 16'd0, 16'd0, 5'b00010, 1);
    flagOp = 4'hB; #1;
    chk("hs_l", 32'(condTrue), 32'h1);
    flagOp = 4'hA; #1;
    chk("lo_l", 32'(condTrue), 32'h0);

`ifdef TRON_PC_HALT_EN
    jump_to(16'd9);
    step(0, 0, 1, 4'hE, 16'd0, 16'd0, 5'd0, 0);     chk("halt_set", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc), 32'h9);
    step(1, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0);     chk("halt_add", 32'(pc), 32'h9);
    jump_to(16'h0100);                                chk("halt_jmp", 32'(pc), 32'h9);
    step(0, 0, 0, 4'h0, 16'd0, 16'd0, 5'b10000, 1); chk("halt_fw", 32'(flags), 32'h10);
`else
    jump_to(16'd9);
    step(0, 0, 1, 4'hE, 16'd0, 16'd0, 5'd0, 0);     chk("self_loop", 32'(pc), 32'h9);
    step(1, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0);     chk("after_self", 32'(pc), 32'hA);
`endif

    // Reset asserted between edges must clear state without waiting for a clock.
    #3 reset = 1;
    #2;
    chk("async_pc", 32'(pc), 32'h0);
    chk("async_flags", 32'(flags), 32'h0);
`ifdef TRON_PC_HALT_EN
    chk("async_halt", 32'(halted), 32'h0);
`endif
    #2 reset = 0;
    @(posedge clk); #1;
    chk("post_rst_hold", 32'(pc), 32'h0);
    step(1, 0, 0, 4'h0, 16'd0, 16'd0, 5'd0, 0);     chk("post_rst_add", 32'(pc), 32'h1);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
